// File: rtl/magnitude_ctrl.sv
// -----------------------------------------------------------------------------
// magnitude_ctrl
//
// Frame sequencer between the gradient stage and the magnitude unit. One
// start_i admits exactly FRAME_W_P x FRAME_H_P gradient beats. Column and row
// position are tracked, border beats are forced to zero, and each beat is
// tagged with start-of-frame / end-of-line / end-of-frame sidebands. done_o
// pulses once the final beat has left the single-entry output register.
//
// Ports
//   clk_i    : clock, all state updates on the rising edge
//   rstn_i   : asynchronous active-low reset
//   start_i  : frame start request, honoured only in IDLE
//   valid_i  : upstream gradient beat valid
//   ready_o  : upstream beat accepted when valid_i & ready_o
//   gx_i     : upstream |Gx|
//   gy_i     : upstream |Gy|
//   valid_o  : beat valid toward magnitude
//   ready_i  : downstream (magnitude) ready
//   gx_o     : gradient x, zero on border beats
//   gy_o     : gradient y, zero on border beats
//   sof_o    : beat is (row 0, col 0)
//   eol_o    : beat is the last column of a line
//   eof_o    : beat is the last beat of the frame
//   busy_o   : sequencer not idle
//   done_o   : one-cycle pulse, frame fully drained
// -----------------------------------------------------------------------------
module magnitude_ctrl #(
  parameter int WIDTH_P   = 8,
  parameter int FRAME_W_P = 640,
  parameter int FRAME_H_P = 480
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               start_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_P-1:0] gx_i,
  input  logic [WIDTH_P-1:0] gy_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] gx_o,
  output logic [WIDTH_P-1:0] gy_o,
  output logic               sof_o,
  output logic               eol_o,
  output logic               eof_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam int COL_W = $clog2(FRAME_W_P);
  localparam int ROW_W = $clog2(FRAME_H_P);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(FRAME_W_P - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_H_P - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [COL_W-1:0]   col_q,   col_d;
  logic [ROW_W-1:0]   row_q,   row_d;
  logic               valid_q, valid_d;
  logic [WIDTH_P-1:0] gx_q,    gx_d;
  logic [WIDTH_P-1:0] gy_q,    gy_d;
  logic               sof_q,   sof_d;
  logic               eol_q,   eol_d;
  logic               eof_q,   eof_d;

  logic out_free;
  logic accept;
  logic col_last;
  logic row_last;
  logic last_beat;
  logic border;

  // The output register can take a new beat if it is empty or is being
  // emptied this cycle; this keeps full throughput without a bubble.
  assign out_free  = ~valid_q | ready_i;
  assign ready_o   = (state_q == ST_ACTIVE) & out_free;
  assign accept    = valid_i & ready_o;

  assign col_last  = (col_q == COL_LAST);
  assign row_last  = (row_q == ROW_LAST);
  assign last_beat = col_last & row_last;
  assign border    = (row_q == '0) | row_last | (col_q == '0) | col_last;

  // done_o is asserted in the DRAIN cycle where the final beat leaves (or
  // has already left) the output register; the state returns to IDLE on
  // the same edge, so busy_o drops one cycle later.
  assign done_o    = (state_q == ST_DRAIN) & out_free;
  assign busy_o    = (state_q != ST_IDLE);

  assign valid_o   = valid_q;
  assign gx_o      = gx_q;
  assign gy_o      = gy_q;
  assign sof_o     = sof_q;
  assign eol_o     = eol_q;
  assign eof_o     = eof_q;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = valid_q;
    gx_d    = gx_q;
    gy_d    = gy_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_ACTIVE;
          col_d   = '0;
          row_d   = '0;
        end
      end
      ST_ACTIVE: begin
        if (accept && last_beat) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (out_free) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Position advances only on an accepted beat. The row saturates at the
    // last line; the next start clears it.
    if (accept) begin
      if (col_last) begin
        col_d = '0;
        if (!row_last) begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    // Output register: load on accept, otherwise drop valid once consumed.
    // Data and sidebands keep their value while stalled.
    if (accept) begin
      valid_d = 1'b1;
      gx_d    = border ? '0 : gx_i;
      gy_d    = border ? '0 : gy_i;
      sof_d   = (row_q == '0) & (col_q == '0);
      eol_d   = col_last;
      eof_d   = last_beat;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      gx_q    <= '0;
      gy_q    <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      gx_q    <= gx_d;
      gy_q    <= gy_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      eof_q   <= eof_d;
    end
  end

endmodule
